// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the open-drain clock/data pair and reports the device ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int SETUP_CYCLES   = 50
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_SEND, S_ACK, S_WAITIDLE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         bit_q, bit_d;
  logic [8:0]         shift_q, shift_d;
  logic               dat_oe_q, dat_oe_d;
  logic               clk_oe_q, clk_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               clk_s1_q, clk_s2_q, clk_prev_q, fall_q;
  logic               dat_s1_q, dat_s2_q;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  // A fall reaches the watchdog three cycles after the pin edge; preloading
  // that latency makes the limit count from the pin edge itself.
  localparam int SYNC_LAT = 3;
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // NOTE: the synchronizer resets to 1 (idle bus level) so that releasing
  // reset cannot manufacture a spurious falling edge.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value,
      // which is what makes this a shift chain rather than a single wire.
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      fall_q     <= clk_prev_q & ~clk_s2_q;
      dat_s1_q   <= ps2_dat_in;
      dat_s2_q   <= dat_s1_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      dat_oe_q <= 1'b0;
      clk_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      dat_oe_q <= dat_oe_d;
      clk_oe_q <= clk_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a variable unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    dat_oe_d = dat_oe_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_start) begin
          state_d = S_INHIBIT;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = {~^tx_data, tx_data};
          err_d   = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d  = S_SETUP;
          cnt_d    = '0;
          dat_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (fall_q) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end else begin
            dat_oe_d = ~shift_q[0];
            shift_d  = {1'b0, shift_q[8:1]};
          end
        end
      end
      S_ACK: begin
        if (fall_q) begin
          err_d   = dat_s2_q;
          state_d = S_WAITIDLE;
          cnt_d   = '0;
        end
      end
      S_WAITIDLE: begin
        dat_oe_d = 1'b0;
        if (clk_s2_q && dat_s2_q) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == S_SETUP && state_d == S_SEND) begin
      wd_d = '0;
    end else if (fall_q) begin
      wd_d = WD_W'(SYNC_LAT);
    end else if (state_q inside {S_SEND, S_ACK, S_WAITIDLE}) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (state_q inside {S_SEND, S_ACK, S_WAITIDLE} && state_d != S_IDLE &&
        wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      state_d  = S_IDLE;
      dat_oe_d = 1'b0;
      err_d    = 1'b1;
      done_d   = 1'b1;
    end
`endif

    busy_d   = (state_d != S_IDLE);
    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_SETUP);
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks each frame out of the host and
// checks captured bits, ACK/NACK reporting, handshake timing, reset abort and (optionally) the watchdog.
module tb_ps2_host_tx;

  localparam int INH  = 300;
  localparam int SET  = 20;
  localparam int HALF = 10;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMO  = 2000;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES(SET)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  always @(posedge CLOCK_50) if (tx_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [7:0] data;
    bit         nack;
    int         restart_at;
    logic [9:0] exp_bits;   // {stop, parity, D7..D0}
    bit         exp_err;
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Starts a transfer and plays the device side. With stop_after>0 the
  // device stops right after driving that fall, leaving its clock low.
  task automatic xfer(input vec_t v, input int stop_after, output logic [9:0] bits,
                      output int inh_n, output int set_m, output bit ok);
    ok = 1'b0; bits = '0; inh_n = 0; set_m = 0;
    tx_data = v.data; tx_start = 1'b1;
    @(negedge CLOCK_50);
    tx_start = 1'b0; tx_data = 8'hA5;
    inh_n = 1;
    while (!ps2_dat_oe && inh_n < INH + 20) begin
      if (inh_n == v.restart_at) begin
        tx_data = 8'h55; tx_start = 1'b1;
      end
      @(negedge CLOCK_50);
      tx_start = 1'b0;
      inh_n++;
    end
    if (!ps2_dat_oe) return;
    while (ps2_clk_oe && set_m < SET + 20) begin
      @(negedge CLOCK_50);
      set_m++;
    end
    if (ps2_clk_oe) return;
    wait_cycles(HALF);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      if (k + 1 == stop_after) begin
        ok = 1'b1;
        return;
      end
      wait_cycles(HALF);
      dev_clk = 1'b1;
      bits[k] = ps2_dat_in;
      wait_cycles(HALF);
    end
    dev_dat = v.nack;
    wait_cycles(HALF);
    dev_clk = 1'b0;
    wait_cycles(HALF);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    ok = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [9:0] bits;
    int         inh_n, set_m, d0;
    bit         ok, seen, err;
    d0 = done_cnt;
    xfer(v, 0, bits, inh_n, set_m, ok);
    check({v.name, "_handshake"}, 32'(ok), 32'd1);
    check({v.name, "_inhibit_len"}, 32'(inh_n), 32'(INH + 1));
    check({v.name, "_setup_len"}, 32'(set_m), 32'(SET));
    check({v.name, "_bits"}, 32'(bits), 32'(v.exp_bits));
    seen = 1'b0; err = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (tx_done) begin
        seen = 1'b1;
        err  = tx_error;
        check({v.name, "_busy_drop"}, 32'(tx_busy), 32'd0);
      end
    end
    check({v.name, "_done_seen"}, 32'(seen), 32'd1);
    check({v.name, "_error"}, 32'(err), 32'(v.exp_err));
    wait_cycles(10);
    check({v.name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({v.name, "_released"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check({v.name, "_error_hold"}, 32'(tx_error), 32'(v.exp_err));
  endtask

  initial begin
    #(20ns * 200000);
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [9:0] bits;
    int         inh_n, set_m, c;
    bit         ok;
    vec_t       rv;

    vecs[0] = '{8'hED, 1'b0, -1, 10'h3ED, 1'b0, "ed_ack"};
    vecs[1] = '{8'h07, 1'b0, -1, 10'h207, 1'b0, "07_par0"};
    vecs[2] = '{8'h00, 1'b0, -1, 10'h300, 1'b0, "00_par1"};
    vecs[3] = '{8'hF4, 1'b1, -1, 10'h2F4, 1'b1, "f4_nack"};
    vecs[4] = '{8'h3C, 1'b0, 100, 10'h33C, 1'b0, "3c_restart"};
    vecs[5] = '{8'hFF, 1'b0, -1, 10'h3FF, 1'b0, "ff_after_rst"};

    wait_cycles(3);
    check("rst_busy",   32'(tx_busy),    32'd0);
    check("rst_done",   32'(tx_done),    32'd0);
    check("rst_error",  32'(tx_error),   32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    Resetn = 1'b1;
    wait_cycles(5);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset mid-frame: after fall 5 the host drives D4=0, so dat_oe is high.
    rv = '{8'h0F, 1'b0, -1, 10'h30F, 1'b0, "0f_abort"};
    xfer(rv, 5, bits, inh_n, set_m, ok);
    check("abort_handshake", 32'(ok), 32'd1);
    wait_cycles(HALF / 2);
    check("abort_pre_dat_oe", 32'(ps2_dat_oe), 32'd1);
    check("abort_pre_busy",   32'(tx_busy),    32'd1);
    #3;
    Resetn = 1'b0;
    #1;
    check("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("abort_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("abort_busy",   32'(tx_busy),    32'd0);
    @(negedge CLOCK_50);
    dev_clk = 1'b1;
    wait_cycles(3);
    Resetn = 1'b1;
    wait_cycles(5);
    run_vec(vecs[5]);

`ifdef PS2_TX_TIMEOUT_EN
    rv = '{8'h5A, 1'b0, -1, 10'h35A, 1'b1, "5a_timeout"};
    xfer(rv, 3, bits, inh_n, set_m, ok);
    check("tmo_handshake", 32'(ok), 32'd1);
    c = 0;
    while (!tx_done && c < TMO + 50) begin
      @(negedge CLOCK_50);
      c++;
    end
    check("tmo_latency_window", 32'(c >= TMO - 2 && c <= TMO + 2), 32'd1);
    check("tmo_error",    32'(tx_error), 32'd1);
    check("tmo_busy",     32'(tx_busy),  32'd0);
    check("tmo_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    dev_clk = 1'b1;
    wait_cycles(10);
    run_vec(vecs[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the send side of the link that the keyboard receiver listens on.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard and reports the device ACK.
- Sits beside the keyboard receiver at top level and shares the open-drain PS2_CLK/PS2_DAT pins.
- Top level converts the *_oe outputs to pin drives: oe=1 drives 0, oe=0 drives Z.

Parameters:
- INHIBIT_CYCLES, 6000, CLOCK_50 cycles the host holds clock low (120 us).
- SETUP_CYCLES, 50, cycles both lines are held low before clock release (1 us).
- TIMEOUT_CYCLES, 1000000, watchdog limit in cycles (20 ms); used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte; sampled when a start is accepted.
- tx_start  in  1  single-cycle request.
- tx_busy  out  1  high from the cycle after acceptance until done.
- tx_done  out  1  one-cycle pulse at end of transfer.
- tx_error  out  1  valid with tx_done: 1 means NACK (or timeout); holds until the next start.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 pulls PS2_CLK low.
- ps2_dat_oe  out  1  1 pulls PS2_DAT low.

Behaviour:
- Reset values: tx_busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_dat_oe=0, state IDLE.
- Reset asserted mid-transfer releases both lines immediately (asynchronous) and discards the byte.
- Pin inputs pass through a 2-flop synchronizer. A "fall" is synchronized clock 1 then 0, registered as a one-cycle strobe.
- tx_start is accepted only in IDLE. It is ignored while busy and not queued.
- On acceptance, tx_data is latched. Odd parity P = ~^tx_data. A bit counter clears.
- States:
  - IDLE: lines released. tx_start -> INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES -> SETUP.
  - SETUP: clk_oe=1, dat_oe=1 (start bit 0) for SETUP_CYCLES -> SEND. clk_oe drops to 0 on entry to SEND.
  - SEND: on each fall, dat_oe is updated within 1 cycle.
    - Falls 1-8 drive D0..D7, LSB first; dat_oe = ~bit.
    - Fall 9 drives P.
    - Fall 10 releases data (stop bit = 1) -> ACK.
  - ACK: on the next fall, sample synchronized data. 0 = ACK (error=0); 1 = NACK (error=1) -> WAITIDLE.
  - WAITIDLE: both lines released. When synchronized clock and data are both 1 for 2 consecutive cycles, pulse tx_done for 1 cycle and drop tx_busy in the same cycle -> IDLE.
- tx_busy rises the cycle after tx_start. Minimum latency to the first line activity is 1 cycle (clk_oe rises with tx_busy).
- Device rising edges are not used; the device samples on its own rising edges.
- Clock glitches shorter than the synchronizer depth may be missed. No other filtering is performed.
- Without the optional feature, a missing device clock stalls the block in SEND/ACK indefinitely; only reset recovers.

Optional Feature:
- Macro: PS2_TX_TIMEOUT_EN.
- Defined: a watchdog counter clears on entering SEND and on every fall.
  - If it reaches TIMEOUT_CYCLES in SEND, ACK or WAITIDLE: both lines are released, tx_error=1, tx_done pulses, state -> IDLE.
- Not defined: no counter is synthesized and the block waits forever, as above.

Test Plan:
- Send 0xED with a device model that ACKs. Data bits seen on device rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1. ACK low -> tx_done=1, tx_error=0, exactly one tx_done pulse.
- Send 0x07: parity must be 0. Send 0x00: parity must be 1. Device checks both. tx_error=0 in each case.
- Device returns NACK (data high on 11th clock) for 0xF4 -> tx_done with tx_error=1; lines released; next start accepted.
- Pulse tx_start again 100 cycles into INHIBIT with a different byte -> ignored; the original byte is transmitted unchanged.
- Assert Resetn=0 after fall 5 -> clk_oe=0 and dat_oe=0 without waiting for a clock edge, busy=0. After release, a new 0xFF send completes normally.
- With PS2_TX_TIMEOUT_EN and a device that stops clocking after fall 3 -> tx_done with tx_error=1 at TIMEOUT_CYCLES ±2 cycles after fall 3.
